keypad_responder: RTL and testbench

- Synthesizable 4x4 keypad emulator. It is the responder side of the row-scan/column-sense keypad interface.
- Sits where the physical keypad would be. Watches the scanner's keypadRow strobes and drives keypadCol as if a chosen key were held.
- Used for on-board demo/self-play and closed-loop bench checks of the guess-number keypad path.
- A host presents a key code. The block holds the key pressed until the scanner has strobed its row enough times, then releases it for a gap.

---
 rtl/keypad_responder_if.sv | 25 ++
 rtl/keypad_responder.sv | 162 ++++++++++++++++
 tb/tb_keypad_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_responder_if.sv
// Host/scanner-facing signal bundle of keypad_responder: keypad row/column
// lines plus the key-press request handshake and status pulses.
interface keypad_responder_if;
    logic [3:0] keypadRow;
    logic [3:0] keypadCol;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       abort;
    logic       press_active;
    logic       done;
    logic       timeout;

    // Host + scanner side
    modport master (
        output keypadRow, key_code, key_valid, abort,
        input  keypadCol, key_ready, press_active, done, timeout
    );

    // Keypad emulator side
    modport slave (
        input  keypadRow, key_code, key_valid, abort,
        output keypadCol, key_ready, press_active, done, timeout
    );
endinterface

// File: rtl/keypad_responder.sv
// 4x4 keypad emulator: holds a host-chosen key against a row-scanning keypad
// controller. Optional contact bounce model is enabled with KEYPAD_BOUNCE_EN.
module keypad_responder #(
    parameter int unsigned MIN_SCANS      = 4,
    parameter int unsigned HOLD_MAX       = 50000,
    parameter int unsigned RELEASE_CYCLES = 20000,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned BOUNCE_CYCLES  = 64
) (
    input  logic                clk,
    input  logic                rst,
    keypad_responder_if.slave   kp
);

    localparam int unsigned HIT_W = $clog2(MIN_SCANS + 1);

    // An out-of-range configuration never accepts a request.
    localparam bit PARAMS_OK = (MIN_SCANS > 0)
                            && (HOLD_MAX > 0)       && (HOLD_MAX < (1 << CNT_W))
                            && (RELEASE_CYCLES > 0) && (RELEASE_CYCLES < (1 << CNT_W))
                            && (BOUNCE_CYCLES < (1 << CNT_W));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         kr_q, kr_d;
    logic [1:0]         kc_q, kc_d;
    logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [3:0]         row_q, row_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic               in_bounce_c;
    logic               contact_c;
    logic               hit_c;
    logic [CNT_W-1:0]   cyc_inc_c;
    logic [HIT_W-1:0]   hit_inc_c;

`ifdef KEYPAD_BOUNCE_EN
    logic [6:0] lfsr_q, lfsr_d;

    // x^7 + x^6 + 1 free-running LFSR chops the contact during the bounce window
    always_comb begin
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 7'h5A;
        else      lfsr_q <= lfsr_d;
    end

    always_comb begin
        in_bounce_c = (state_q == PRESS) && (cyc_cnt_q < CNT_W'(BOUNCE_CYCLES));
        contact_c   = !in_bounce_c || lfsr_q[0];
    end
`else
    always_comb begin
        in_bounce_c = 1'b0;
        contact_c   = 1'b1;
    end
`endif

    // Falling edge on the held key's row, ignored while the contact bounces
    always_comb begin
        hit_c     = (state_q == PRESS) && row_q[kr_q] && !kp.keypadRow[kr_q] && !in_bounce_c;
        cyc_inc_c = (cyc_cnt_q == {CNT_W{1'b1}}) ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);
        hit_inc_c = (hit_cnt_q == HIT_W'(MIN_SCANS)) ? hit_cnt_q : hit_cnt_q + HIT_W'(1);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            kr_q      <= 2'd0;
            kc_q      <= 2'd0;
            hit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            row_q     <= 4'b1111;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kr_q      <= kr_d;
            kc_q      <= kc_d;
            hit_cnt_q <= hit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            row_q     <= row_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and counter logic; abort beats done, done beats timeout
    always_comb begin
        state_d   = state_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        hit_cnt_d = hit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        row_d     = kp.keypadRow;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (kp.key_valid && PARAMS_OK) begin
                    kr_d      = kp.key_code[3:2];
                    kc_d      = kp.key_code[1:0];
                    hit_cnt_d = '0;
                    cyc_cnt_d = '0;
                    state_d   = PRESS;
                end
            end
            PRESS: begin
                cyc_cnt_d = cyc_inc_c;
                if (hit_c) hit_cnt_d = hit_inc_c;
                if (kp.abort) begin
                    state_d   = RELEASE;
                    cyc_cnt_d = '0;
                end else if (hit_c && (hit_cnt_q == HIT_W'(MIN_SCANS - 1))) begin
                    done_d    = 1'b1;
                    state_d   = RELEASE;
                    cyc_cnt_d = '0;
                end else if (cyc_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                    cyc_cnt_d = '0;
                end
            end
            RELEASE: begin
                if (cyc_cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
                    state_d   = IDLE;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_inc_c;
                end
            end
            default: begin
                state_d   = IDLE;
                cyc_cnt_d = '0;
            end
        endcase
    end

    // Outputs; the pressed column follows its row strobe combinationally
    always_comb begin
        kp.keypadCol    = 4'b1111;
        kp.key_ready    = (state_q == IDLE) && PARAMS_OK;
        kp.press_active = (state_q == PRESS);
        kp.done         = done_q;
        kp.timeout      = timeout_q;
        if (state_q == PRESS) begin
            kp.keypadCol[kc_q] = kp.keypadRow[kr_q] || !contact_c;
        end
    end

endmodule

// File: tb/tb_keypad_responder.sv
// Self-checking bench for keypad_responder: directed and randomized presses
// checked cycle by cycle against an outcome model computed from row sequences.
module tb_keypad_responder;

    localparam int unsigned MIN_SCANS      = 4;
    localparam int unsigned HOLD_MAX       = 100;
    localparam int unsigned RELEASE_CYCLES = 20;
    localparam int unsigned CNT_W          = 16;
    localparam int          HM             = int'(HOLD_MAX);
    localparam int          RC             = int'(RELEASE_CYCLES);

    typedef enum int {K_DONE, K_TIMEOUT, K_ABORT} kind_e;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_responder_if kp ();

    keypad_responder #(
        .MIN_SCANS      (MIN_SCANS),
        .HOLD_MAX       (HOLD_MAX),
        .RELEASE_CYCLES (RELEASE_CYCLES),
        .CNT_W          (CNT_W),
        .BOUNCE_CYCLES  (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    int tests = 0;
    int fails = 0;
    logic [3:0] rowseq [HM];

    // {keypadCol, press_active, key_ready, done, timeout}
    function automatic logic [7:0] snap();
        return {kp.keypadCol, kp.press_active, kp.key_ready, kp.done, kp.timeout};
    endfunction

    function automatic logic [7:0] expv(input logic [3:0] c, input logic pa, input logic rdy,
                                        input logic d, input logic t);
        return {c, pa, rdy, d, t};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic a, input logic v, input logic [3:0] k);
        @(posedge clk);
        #1;
        kp.keypadRow = r;
        kp.abort     = a;
        kp.key_valid = v;
        kp.key_code  = k;
        #1;
    endtask

    // Outcome of a press from the row sequence: count falling edges of row kr
    function automatic void predict(input logic [3:0] prev, input logic [1:0] kr, input int abort_at,
                                    output kind_e kind, output int end_i);
        int   hits;
        logic pb;
        logic cur;
        hits  = 0;
        pb    = prev[kr];
        kind  = K_TIMEOUT;
        end_i = HM - 1;
        for (int i = 0; i < HM; i++) begin
            cur = rowseq[i][kr];
            if (i == abort_at) begin
                kind  = K_ABORT;
                end_i = i;
                return;
            end
            if (pb && !cur) begin
                hits++;
                if (hits == int'(MIN_SCANS)) begin
                    kind  = K_DONE;
                    end_i = i;
                    return;
                end
            end
            pb = cur;
        end
    endfunction

    task automatic fill_rotate(input int per, input int start);
        logic [3:0] t;
        for (int i = 0; i < HM; i++) begin
            t = 4'(1) << ((start + i / per) % 4);
            rowseq[i] = ~t;
        end
    endtask

    task automatic fill_const(input logic [3:0] v);
        for (int i = 0; i < HM; i++) rowseq[i] = v;
    endtask

    task automatic fill_random(input logic [1:0] kr, input int k);
        logic       b;
        logic [3:0] r;
        b = 1'($urandom);
        for (int i = 0; i < HM; i++) begin
            r = 4'($urandom);
            if ($urandom_range(1, k) == 1) b = ~b;
            r[kr] = b;
            rowseq[i] = r;
        end
    endtask

    task automatic run_press(input string tag, input logic [3:0] key, input logic [3:0] prev,
                             input int abort_at);
        kind_e      kind;
        int         end_i;
        logic [3:0] r;
        logic [3:0] ec;
        predict(prev, key[3:2], abort_at, kind, end_i);
        drive(prev, 1'b0, 1'b1, key);
        chk({tag, "/accept"}, snap(), expv(4'hF, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i <= end_i; i++) begin
            r = rowseq[i];
            drive(r, 1'(i == abort_at), 1'($urandom), 4'($urandom));
            ec = 4'hF;
            ec[key[1:0]] = r[key[3:2]];
            chk({tag, "/press"}, snap(), expv(ec, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        for (int j = 0; j < RC; j++) begin
            drive(4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            chk({tag, "/release"}, snap(),
                expv(4'hF, 1'b0, 1'b0, 1'((j == 0) && (kind == K_DONE)),
                     1'((j == 0) && (kind == K_TIMEOUT))));
        end
        for (int j = 0; j < 2; j++) begin
            drive(4'hF, 1'b0, 1'b0, 4'h0);
            chk({tag, "/idle"}, snap(), expv(4'hF, 1'b0, 1'b1, 1'b0, 1'b0));
        end
    endtask

    initial begin
        kp.keypadRow = 4'hF;
        kp.abort     = 1'b0;
        kp.key_valid = 1'b0;
        kp.key_code  = 4'h0;
        rst          = 1'b0;
        #1;
        chk("reset", snap(), expv(4'hF, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Row 1 strobed every 32 cycles from the first PRESS cycle: hits at 0,32,64,96
        fill_rotate(8, 1);
        run_press("clean", 4'h6, 4'b1110, -1);

        // Row 3 never strobed: timeout after HOLD_MAX PRESS cycles
        fill_const(4'b1110);
        run_press("timeout", 4'hC, 4'b1110, -1);

        // Abort after two hits
        fill_rotate(8, 1);
        run_press("abort", 4'h6, 4'b1110, 40);

        // Abort on the same cycle as the completing hit
        fill_rotate(8, 1);
        run_press("abort_vs_done", 4'h6, 4'b1110, 96);

        // Fourth hit lands on cycle HOLD_MAX-1
        fill_const(4'hF);
        rowseq[5][2] = 1'b0;
        rowseq[40][2] = 1'b0;
        rowseq[70][2] = 1'b0;
        rowseq[HM-1][2] = 1'b0;
        run_press("tiebreak", 4'h9, 4'hF, -1);

        // No row driven at all
        fill_const(4'hF);
        run_press("rows_idle", 4'h5, 4'hF, -1);

        // Async reset while the key is visibly pressed
        drive(4'hE, 1'b0, 1'b1, 4'h0);
        drive(4'hE, 1'b0, 1'b0, 4'h0);
        chk("rst_pre", snap(), expv(4'hE, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        rst = 1'b0;
        #1;
        chk("rst_async", snap(), expv(4'hF, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(4'hE, 1'b0, 1'b0, 4'h0);
            chk("rst_after", snap(), expv(4'hF, 1'b0, 1'b1, 1'b0, 1'b0));
        end

        // Randomized presses
        for (int n = 0; n < 16; n++) begin
            logic [3:0] key;
            int         ab;
            key = 4'($urandom);
            fill_random(key[3:2], int'($urandom_range(2, 40)));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, HOLD_MAX - 1)) : -1;
            run_press("random", key, 4'($urandom), ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
